// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: diff = a - b - bin, LSB first.
// One subtractor cell, registered borrow, start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             x;
  logic             y;
  logic             d;
  logic             bnx;
  logic [WIDTH-1:0] res_nx;

  // full-subtractor cell on the current LSBs
  always_comb begin
    x      = sa[0];
    y      = sb[0];
    d      = x ^ y ^ brw;
    bnx    = (~x & y) | (~(x ^ y) & brw);
    res_nx = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));
  end

  // sequencer, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            brw   <= bin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          brw <= bnx;
          res <= res_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff  <= res_nx;
            bout  <= bnx;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8 and WIDTH=1).
// Arithmetic reference model, per-cycle monitor on busy/done/diff.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  logic         start1;
  logic [0:0]   a1;
  logic [0:0]   b1;
  logic         bin1;
  logic [0:0]   diff1;
  logic         bout1;
  logic         busy1;
  logic         done1;

  serial_subtractor #(.WIDTH(W)) u8 (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .diff (diff),
    .bout (bout),
    .busy (busy),
    .done (done)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk  (clk),
    .rst  (rst),
    .start(start1),
    .a    (a1),
    .b    (b1),
    .bin  (bin1),
    .diff (diff1),
    .bout (bout1),
    .busy (busy1),
    .done (done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    int           acc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d",
               nm, cyc, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic z,
                                 input int acc);
    exp_t e;
    logic [W:0] f;
    f = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, z};
    e.d   = f[W-1:0];
    e.bo  = f[W];
    e.acc = acc;
    return e;
  endfunction

  // monitor: busy window, done timing, held/updated result
  initial begin
    logic         rprev;
    logic [W-1:0] hd;
    logic         hb;
    logic         eb;
    logic         ed;
    rprev = 1'b0;
    hd    = '0;
    hb    = 1'b0;
    forever begin
      @(negedge clk);
      if (rprev) begin
        q.delete();
        hd = '0;
        hb = 1'b0;
      end
      rprev = rst;
      eb = q.size() > 0 && cyc >= q[0].acc && cyc < q[0].acc + W;
      ed = q.size() > 0 && cyc == q[0].acc + W;
      chk("busy", busy, eb);
      chk("done", done, ed);
      if (ed) begin
        hd = q[0].d;
        hb = q[0].bo;
        void'(q.pop_front());
      end
      chk("diff", diff, hd);
      chk("bout", bout, hb);
    end
  end

  // called just after an edge with the DUT idle; next edge accepts
  task automatic issue(input logic [W-1:0] ta,
                       input logic [W-1:0] tb,
                       input logic tbin,
                       input bit hold,
                       input logic [W-1:0] ja,
                       input logic [W-1:0] jb);
    a     = ta;
    b     = tb;
    bin   = tbin;
    start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(model(ta, tb, tbin, cyc));
    a   = ja;
    b   = jb;
    bin = 1'($urandom);
    if (!hold) start = 1'b0;
    repeat (W + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] v;
    int         f;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    bin1   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;

    issue(8'd100, 8'd37, 1'b0, 1'b0, 8'd0, 8'd0);
    issue(8'd5, 8'd10, 1'b0, 1'b0, 8'd0, 8'd0);
    issue(8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 8'd0);
    issue(8'd255, 8'd255, 1'b0, 1'b0, 8'd0, 8'd0);

    issue(8'd200, 8'd1, 1'b0, 1'b1, 8'd9, 8'd9);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    issue(8'd100, 8'd37, 1'b0, 1'b0, 8'd0, 8'd0);
    a     = 8'd50;
    b     = 8'd20;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(model(8'd50, 8'd20, 1'b0, cyc));
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_bout", bout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk);
    #1;
    issue(8'd7, 8'd3, 1'b1, 1'b0, 8'd0, 8'd0);

    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1,
            W'($urandom), W'($urandom));
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      v      = 3'(i);
      a1     = v[2];
      b1     = v[1];
      bin1   = v[0];
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      chk("w1_busy", busy1, 1);
      @(posedge clk);
      #1;
      f = int'(v[2]) - int'(v[1]) - int'(v[0]);
      chk("w1_done", done1, 1);
      chk("w1_diff", diff1, f & 1);
      chk("w1_bout", bout1, f < 0 ? 1 : 0);
      @(posedge clk);
      #1;
      chk("w1_idle", done1, 0);
    end

    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
